// File: rtl/conv_stream_sequencer.sv
// conv_stream_sequencer: skews activation vectors into a systolic array and
// returns deskewed column results through a credit-controlled output FIFO.
module conv_stream_sequencer #(
    parameter int DATA_W     = 8,
    parameter int OUT_W      = 24,
    parameter int N_ROWS     = 9,
    parameter int N_COLS     = 3,
    parameter int ARR_LAT    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      ctrl_start,
    input  logic                      ctrl_abort,
    input  logic [CNT_W-1:0]          cfg_num_vectors,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_ROWS*DATA_W-1:0]  in_act,
    output logic [N_ROWS*DATA_W-1:0]  arr_act,
    input  logic [N_COLS*OUT_W-1:0]   arr_psum,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_COLS*OUT_W-1:0]   out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      flag_done
);
    localparam int PIPE = ARR_LAT + N_COLS;
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_P = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [CNT_W-1:0] num_q, acc_cnt, inflight, fifo_cnt;
    logic [PIPE-1:0] tag_sr, last_sr;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [N_COLS*OUT_W-1:0] mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem;
    logic [N_COLS*OUT_W-1:0] aligned;
    logic accept, push, pop, is_last, flush;

    assign accept  = in_valid & in_ready;
    assign is_last = acc_cnt == num_q - CNT_W'(1);
    assign flush   = ctrl_abort && state != IDLE;
    assign push    = tag_sr[PIPE-1];
    assign pop     = out_ready && fifo_cnt != '0;

    // state register
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) state <= IDLE;
        else state <= state_nx;

    // next-state logic; abort overrides every other transition
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ctrl_start) state_nx = cfg_num_vectors == '0 ? DONE : RUN;
            RUN:     if (accept && is_last) state_nx = DRAIN;
            DRAIN:   if (inflight == '0 && fifo_cnt == '0) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // outputs decoded from state and credits; a pop frees its credit next cycle
    always_comb begin
        in_ready  = state == RUN && acc_cnt < num_q && inflight + fifo_cnt < DEPTH_C;
        busy      = state != IDLE;
        flag_done = state == DONE;
    end

    // run length, accept count and in-flight credit tracking
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            num_q    <= '0;
            acc_cnt  <= '0;
            inflight <= '0;
        end else if (flush) begin
            num_q    <= '0;
            acc_cnt  <= '0;
            inflight <= '0;
        end else begin
            if (state == IDLE && ctrl_start) begin
                num_q   <= cfg_num_vectors;
                acc_cnt <= '0;
            end else if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
            if (accept != push) inflight <= accept ? inflight + CNT_W'(1) : inflight - CNT_W'(1);
        end

    for (genvar y = 0; y < N_ROWS; y++) begin : g_skew
        logic [DATA_W-1:0] sr [0:y];
        // lane y reaches its row after 1+y registers; bubbles inject zeros
        always_ff @(posedge clk or negedge nrst)
            if (!nrst) for (int k = 0; k <= y; k++) sr[k] <= '0;
            else begin
                sr[0] <= accept ? in_act[y*DATA_W +: DATA_W] : '0;
                for (int k = 1; k <= y; k++) sr[k] <= sr[k-1];
            end
        assign arr_act[y*DATA_W +: DATA_W] = sr[y];
    end

    for (genvar x = 0; x < N_COLS; x++) begin : g_deskew
        localparam int D = N_COLS - 1 - x;
        if (D == 0) begin : g_pass
            assign aligned[x*OUT_W +: OUT_W] = arr_psum[x*OUT_W +: OUT_W];
        end else begin : g_dly
            logic [OUT_W-1:0] sr [0:D-1];
            // earlier columns wait for the last column to line up
            always_ff @(posedge clk or negedge nrst)
                if (!nrst) for (int k = 0; k < D; k++) sr[k] <= '0;
                else begin
                    sr[0] <= arr_psum[x*OUT_W +: OUT_W];
                    for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
                end
            assign aligned[x*OUT_W +: OUT_W] = sr[D-1];
        end
    end

    // valid and last tags travel alongside the data through the array pipeline
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            tag_sr  <= '0;
            last_sr <= '0;
        end else if (flush) begin
            tag_sr  <= '0;
            last_sr <= '0;
        end else begin
            tag_sr  <= PIPE'({tag_sr, accept});
            last_sr <= PIPE'({last_sr, accept & is_last});
        end

    // FIFO pointers and occupancy; push and pop may coincide even when full
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr == LAST_P ? '0 : wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr == LAST_P ? '0 : rd_ptr + PW'(1);
            if (push != pop) fifo_cnt <= push ? fifo_cnt + CNT_W'(1) : fifo_cnt - CNT_W'(1);
        end

    // FIFO storage needs no reset; reads are masked while empty
    always_ff @(posedge clk)
        if (push) begin
            mem[wr_ptr]      <= aligned;
            last_mem[wr_ptr] <= last_sr[PIPE-1];
        end

    assign out_valid = fifo_cnt != '0;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign out_last  = out_valid & last_mem[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (!nrst)
        !(push && !pop && fifo_cnt == DEPTH_C));
endmodule

// File: tb/tb_conv_stream_sequencer.sv
// tb_conv_stream_sequencer: directed and randomised scenario checks with an array model and scoreboard
module tb_conv_stream_sequencer;
    localparam int DATA_W = 8, OUT_W = 24, N_ROWS = 9, N_COLS = 3, ARR_LAT = 4;
    localparam int FIFO_DEPTH = 8, CNT_W = 16;
    localparam int PIPE = ARR_LAT + N_COLS;
    localparam int VW = N_ROWS * DATA_W, PWID = N_COLS * OUT_W;
    localparam int H = (N_ROWS > PIPE ? N_ROWS : PIPE) + 1;

    logic clk = 0, nrst = 0, ctrl_start = 0, ctrl_abort = 0, in_valid = 0, out_ready = 0;
    logic [CNT_W-1:0] cfg_num_vectors = '0;
    logic [VW-1:0] in_act = '0, arr_act;
    logic [PWID-1:0] arr_psum, out_data;
    logic in_ready, out_valid, out_last, busy, flag_done;

    int errors = 0, checks = 0;
    int acc_idx = 0, run_num = 0;
    logic [VW-1:0] hd [H];
    logic [H-1:0] hv = '0;
    logic [PWID:0] exp_q [$];

    always #5 clk = ~clk;

    conv_stream_sequencer #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .N_ROWS(N_ROWS), .N_COLS(N_COLS),
        .ARR_LAT(ARR_LAT), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .nrst(nrst), .ctrl_start(ctrl_start), .ctrl_abort(ctrl_abort),
        .cfg_num_vectors(cfg_num_vectors), .in_valid(in_valid), .in_ready(in_ready),
        .in_act(in_act), .arr_act(arr_act), .arr_psum(arr_psum), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy),
        .flag_done(flag_done)
    );

    function automatic logic [OUT_W-1:0] col(input logic [VW-1:0] v, input int x);
        int s = 0;
        for (int y = 0; y < N_ROWS; y++) s += int'(v[y*DATA_W +: DATA_W]) * (y + 1 + 3 * x);
        return OUT_W'(s);
    endfunction

    function automatic logic [PWID-1:0] res(input logic [VW-1:0] v);
        logic [PWID-1:0] r;
        for (int x = 0; x < N_COLS; x++) r[x*OUT_W +: OUT_W] = col(v, x);
        return r;
    endfunction

    // history of accepted vectors and expected outputs
    always @(posedge clk) begin
        if (in_valid && in_ready) begin
            exp_q.push_back({acc_idx == run_num - 1, res(in_act)});
            acc_idx++;
        end
        hv <= H'({hv, in_valid & in_ready});
        hd[0] <= (in_valid && in_ready) ? in_act : '0;
        for (int k = 1; k < H; k++) hd[k] <= hd[k-1];
    end

    // array contract: column x of the vector accepted at t shows at t+1+ARR_LAT+x
    always_comb begin
        arr_psum = '0;
        for (int x = 0; x < N_COLS; x++)
            arr_psum[x*OUT_W +: OUT_W] = hv[ARR_LAT+x] ? col(hd[ARR_LAT+x], x) : '0;
    end

    task automatic start_run(input int n);
        cfg_num_vectors = CNT_W'(n);
        run_num = n;
        acc_idx = 0;
        ctrl_start = 1;
        @(negedge clk);
        ctrl_start = 0;
    endtask

    task automatic test_reset;
        nrst = 0;
        repeat (2) @(negedge clk);
        checks++; if ({in_ready, out_valid, out_last, busy, flag_done} !== 5'b0)
            begin errors++; $display("FAIL reset_flags: got %b want 00000", {in_ready, out_valid, out_last, busy, flag_done}); end
        checks++; if (arr_act !== '0) begin errors++; $display("FAIL reset_arr_act: got %h want 0", arr_act); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        nrst = 1;
        @(negedge clk);
        checks++; if ({in_ready, out_valid, busy} !== 3'b0)
            begin errors++; $display("FAIL post_reset_idle: got %b want 000", {in_ready, out_valid, busy}); end
    endtask

    task automatic test_basic;
        logic [VW-1:0] ea;
        logic [PWID:0] e;
        start_run(5);
        in_valid = 1;
        out_ready = 1;
        for (int k = 1; k <= 17; k++) begin
            for (int y = 0; y < N_ROWS; y++) in_act[y*DATA_W +: DATA_W] = DATA_W'(k * 17 + y * 3);
            for (int y = 0; y < N_ROWS; y++) ea[y*DATA_W +: DATA_W] = hv[y] ? hd[y][y*DATA_W +: DATA_W] : '0;
            checks++; if (in_ready !== (k <= 5)) begin errors++; $display("FAIL basic_in_ready c%0d: got %b want %b", k, in_ready, k <= 5); end
            checks++; if (out_valid !== (k >= 9 && k <= 13)) begin errors++; $display("FAIL basic_out_valid c%0d: got %b want %b", k, out_valid, k >= 9 && k <= 13); end
            checks++; if (flag_done !== (k == 15)) begin errors++; $display("FAIL basic_flag_done c%0d: got %b want %b", k, flag_done, k == 15); end
            checks++; if (busy !== (k <= 15)) begin errors++; $display("FAIL basic_busy c%0d: got %b want %b", k, busy, k <= 15); end
            checks++; if (arr_act !== ea) begin errors++; $display("FAIL basic_skew c%0d: got %h want %h", k, arr_act, ea); end
            if (out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++; if ({out_last, out_data} !== e) begin errors++; $display("FAIL basic_out c%0d: got %h want %h", k, {out_last, out_data}, e); end
            end
            @(negedge clk);
        end
        in_valid = 0;
        out_ready = 0;
    endtask

    task automatic test_stream(input int n, input int pv, input int pr, input bit poke);
        int popped = 0, k = 0;
        bit done = 0;
        logic [PWID:0] e;
        start_run(n);
        while (!done && k < 4000) begin
            if (flag_done) done = 1;
            else begin
                checks++; if (exp_q.size() > FIFO_DEPTH) begin errors++; $display("FAIL stream_credit: got %0d want <=%0d", exp_q.size(), FIFO_DEPTH); end
                in_valid = $urandom_range(99) < pv;
                out_ready = $urandom_range(99) < pr;
                in_act = VW'({$urandom(), $urandom(), $urandom()});
                ctrl_start = poke && k == 2;
                cfg_num_vectors = 1;
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin errors++; $display("FAIL stream_extra: got %h want none", out_data); end
                    else begin
                        e = exp_q.pop_front();
                        if ({out_last, out_data} !== e) begin errors++; $display("FAIL stream_out #%0d: got %h want %h", popped, {out_last, out_data}, e); end
                    end
                    popped++;
                end
                @(negedge clk);
                k++;
            end
        end
        in_valid = 0;
        out_ready = 0;
        ctrl_start = 0;
        checks++; if (!done || popped != n || exp_q.size() != 0)
            begin errors++; $display("FAIL stream_end: got done=%0d popped=%0d left=%0d want done=1 popped=%0d left=0", done, popped, exp_q.size(), n); end
        @(negedge clk);
        checks++; if ({busy, flag_done} !== 2'b0) begin errors++; $display("FAIL stream_idle: got %b want 00", {busy, flag_done}); end
    endtask

    task automatic test_backpressure;
        int acc = 0, popped = 0, k = 0;
        logic [PWID:0] e;
        start_run(10);
        in_valid = 1;
        out_ready = 0;
        for (int i = 0; i < 20; i++) begin
            in_act = VW'({$urandom(), $urandom(), $urandom()});
            if (in_ready) acc++;
            @(negedge clk);
        end
        checks++; if (acc != FIFO_DEPTH) begin errors++; $display("FAIL bp_accepts: got %0d want %0d", acc, FIFO_DEPTH); end
        checks++; if ({in_ready, out_valid} !== 2'b01) begin errors++; $display("FAIL bp_stall: got %b want 01", {in_ready, out_valid}); end
        out_ready = 1;
        while (!flag_done && k < 200) begin
            in_act = VW'({$urandom(), $urandom(), $urandom()});
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra: got %h want none", out_data); end
                else begin
                    e = exp_q.pop_front();
                    if ({out_last, out_data} !== e) begin errors++; $display("FAIL bp_out #%0d: got %h want %h", popped, {out_last, out_data}, e); end
                end
                popped++;
            end
            @(negedge clk);
            k++;
        end
        checks++; if (!flag_done || popped != 10) begin errors++; $display("FAIL bp_end: got done=%b popped=%0d want done=1 popped=10", flag_done, popped); end
        in_valid = 0;
        out_ready = 0;
        @(negedge clk);
    endtask

    task automatic test_zero;
        in_valid = 1;
        start_run(0);
        checks++; if ({flag_done, busy, in_ready} !== 3'b110) begin errors++; $display("FAIL zero_done: got %b want 110", {flag_done, busy, in_ready}); end
        @(negedge clk);
        checks++; if ({flag_done, busy, in_ready} !== 3'b000) begin errors++; $display("FAIL zero_idle: got %b want 000", {flag_done, busy, in_ready}); end
        in_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_abort;
        int seen = 0;
        start_run(3);
        in_valid = 1;
        out_ready = 0;
        repeat (4) @(negedge clk);
        in_valid = 0;
        checks++; if ({busy, in_ready, out_valid} !== 3'b100 || exp_q.size() != 3)
            begin errors++; $display("FAIL abort_pre: got %b acc=%0d want 100 acc=3", {busy, in_ready, out_valid}, exp_q.size()); end
        ctrl_abort = 1;
        @(negedge clk);
        ctrl_abort = 0;
        checks++; if ({busy, out_valid, flag_done} !== 3'b000) begin errors++; $display("FAIL abort_idle: got %b want 000", {busy, out_valid, flag_done}); end
        repeat (12) begin
            if (out_valid || flag_done) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles want 0", seen); end
        exp_q.delete();
        test_stream(2, 100, 100, 0);
    endtask

    task automatic test_async_reset;
        start_run(20);
        in_valid = 1;
        out_ready = 1;
        repeat (11) begin
            in_act = VW'({$urandom(), $urandom(), $urandom()});
            @(negedge clk);
        end
        checks++; if ({busy, out_valid} !== 2'b11) begin errors++; $display("FAIL areset_pre: got %b want 11", {busy, out_valid}); end
        #2 nrst = 0;
        #1;
        checks++; if ({in_ready, out_valid, out_last, busy, flag_done} !== 5'b0 || arr_act !== '0 || out_data !== '0)
            begin errors++; $display("FAIL areset_outputs: got %b %h %h want 0", {in_ready, out_valid, out_last, busy, flag_done}, arr_act, out_data); end
        in_valid = 0;
        out_ready = 0;
        exp_q.delete();
        @(negedge clk);
        nrst = 1;
        repeat (10) @(negedge clk);
        checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL areset_empty: got %b want 00", {out_valid, busy}); end
        test_stream(4, 70, 70, 0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_stream(200, 50, 50, 0);
        test_zero;
        test_stream(3, 100, 100, 1);
        test_abort;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
